// File: rtl/vga_480p_pkg.sv
// Shared 640x480 raster constants and types for the scrolling text strip.
package vga_480p_pkg;

  localparam int HA_END     = 639;
  localparam int HS_STA     = 655;
  localparam int HS_END     = 751;
  localparam int LINE_LAST  = 799;
  localparam int VA_END     = 479;
  localparam int VS_STA     = 489;
  localparam int VS_END     = 491;
  localparam int FRAME_LAST = 524;

  typedef logic [9:0] coord_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_GAP
  } arb_state_t;

endpackage

// File: rtl/text_ram_arb.sv
// Character RAM port owner: display fetch wins, host writes squeeze in
// outside the fetch window through a one-shot grant.
module text_ram_arb
  import vga_480p_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk_pix,
  input  logic              rst,
  input  logic              disp_busy,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  output logic              wr_gnt
);

  arb_state_t        state_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic              ram_we_q;
  logic [7:0]        ram_wdata_q;
  logic              wr_gnt_q;

  // The GAP state swallows the writer's one-cycle-late wr_req drop so a
  // single request can never be granted twice.
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      wr_gnt_q    <= 1'b0;
    end else begin
      ram_we_q <= 1'b0;
      wr_gnt_q <= 1'b0;
      if (disp_busy) begin
        ram_addr_q <= fetch_addr;
      end
      case (state_q)
        ARB_IDLE: begin
          if (wr_req && !disp_busy) begin
            state_q     <= ARB_ISSUE;
            ram_addr_q  <= wr_addr;
            ram_we_q    <= 1'b1;
            ram_wdata_q <= wr_data;
            wr_gnt_q    <= 1'b1;
          end
        end
        ARB_ISSUE: state_q <= ARB_GAP;
        ARB_GAP:   state_q <= ARB_IDLE;
        default:   state_q <= ARB_IDLE;
      endcase
    end
  end

  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;
  assign wr_gnt    = wr_gnt_q;

endmodule

// File: rtl/text_scroll_ctrl.sv
// Running-line sequencer: per-frame scroll offset, strip geometry and the
// two-stage fetch pipeline feeding the font ROM.
module text_scroll_ctrl
  import vga_480p_pkg::*;
#(
  parameter int TEXT_LEN = 64,
  parameter int CHAR_W   = 8,
  parameter int CHAR_H   = 16,
  parameter int ROW_TOP  = 224,
  parameter int SPEED    = 2,
  parameter int ADDR_W   = $clog2(TEXT_LEN)
) (
  input  logic              clk_pix,
  input  logic              rst,
  input  logic [9:0]        sx,
  input  logic [9:0]        sy,
  input  logic              data_en,
  input  logic              enable,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  output logic              wr_gnt,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic [7:0]        char_code,
  output logic [3:0]        font_row,
  output logic [2:0]        font_col,
  output logic              strip_en
);

  localparam int COL_W = $clog2(CHAR_W);
  localparam int P_W   = ADDR_W + COL_W;

  logic           in_rows;
  logic           disp_busy;
  logic [P_W-1:0] p;
  logic [3:0]     row_rel;
  logic [P_W-1:0] offset_q, offset_d;

  logic [3:0] row1_q, font_row_q;
  logic [2:0] col1_q, font_col_q;
  logic       en1_q, strip_en_q;
  logic       vld1_q, vld2_q;

  // Offset only moves on the first pixel of vertical blanking, so every
  // visible line of a frame sees the same value.
  always_comb begin
    in_rows   = (sy >= coord_t'(ROW_TOP)) && (sy < coord_t'(ROW_TOP + CHAR_H));
    disp_busy = in_rows && (sx <= coord_t'(HA_END));
    p         = P_W'(sx) + offset_q;
    row_rel   = sy[3:0] - 4'(ROW_TOP);
    offset_d  = offset_q;
    if (enable && (sx == '0) && (sy == coord_t'(VA_END + 1))) begin
      offset_d = offset_q + P_W'(SPEED);
    end
  end

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      offset_q   <= '0;
      row1_q     <= '0;
      col1_q     <= '0;
      en1_q      <= 1'b0;
      vld1_q     <= 1'b0;
      font_row_q <= '0;
      font_col_q <= '0;
      strip_en_q <= 1'b0;
      vld2_q     <= 1'b0;
    end else begin
      offset_q   <= offset_d;
      row1_q     <= row_rel;
      col1_q     <= p[COL_W-1:0];
      en1_q      <= in_rows && data_en;
      vld1_q     <= disp_busy;
      font_row_q <= row1_q;
      font_col_q <= col1_q;
      strip_en_q <= en1_q;
      vld2_q     <= vld1_q;
    end
  end

  text_ram_arb #(
    .ADDR_W(ADDR_W)
  ) u_arb (
    .clk_pix   (clk_pix),
    .rst       (rst),
    .disp_busy (disp_busy),
    .fetch_addr(p[P_W-1:COL_W]),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .wr_gnt    (wr_gnt)
  );

  // Read data outside a fetch slot may be host-write readback; blank it.
  assign char_code = vld2_q ? ram_rdata : 8'h00;
  assign font_row  = font_row_q;
  assign font_col  = font_col_q;
  assign strip_en  = strip_en_q;

endmodule

// File: tb/tb_text_scroll_ctrl.sv
// Bench for text_scroll_ctrl: a behavioural RAM plus an arithmetic reference
// of the strip (offset, char index, glyph row/col) driven by random pixels.
module tb_text_scroll_ctrl;

  localparam int TEXT_LEN = 64;
  localparam int CHAR_H   = 16;
  localparam int ROW_TOP  = 224;
  localparam int SPEED    = 2;
  localparam int ADDR_W   = 6;
  localparam int STRIP_PX = TEXT_LEN * 8;

  logic              clk_pix = 1'b0;
  logic              rst;
  logic [9:0]        sx, sy;
  logic              data_en, enable;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              wr_gnt;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;
  logic [7:0]        char_code;
  logic [3:0]        font_row;
  logic [2:0]        font_col;
  logic              strip_en;

  always #5 clk_pix = ~clk_pix;

  text_scroll_ctrl dut (
    .clk_pix  (clk_pix),
    .rst      (rst),
    .sx       (sx),
    .sy       (sy),
    .data_en  (data_en),
    .enable   (enable),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_gnt   (wr_gnt),
    .ram_addr (ram_addr),
    .ram_we   (ram_we),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .char_code(char_code),
    .font_row (font_row),
    .font_col (font_col),
    .strip_en (strip_en)
  );

  // Single-port character RAM with one-cycle synchronous read.
  logic [7:0] ramMem [TEXT_LEN];
  always @(posedge clk_pix) begin
    if (ram_we) ramMem[ram_addr] <= ram_wdata;
    ram_rdata <= ramMem[ram_addr];
  end

  int         checks = 0;
  int         fails  = 0;
  int         refOff = 0;
  logic [7:0] refMem [TEXT_LEN];

  bit         pendValid = 0;
  int         pendCode, pendRow, pendCol, pendEn;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit inRows(input int y);
    return (y >= ROW_TOP) && (y < ROW_TOP + CHAR_H);
  endfunction

  // Drive one pixel; check its fetch address one cycle on and the previous
  // pixel's glyph outputs, which arrive two cycles after it was driven.
  task automatic applyStimulus(input int x, input int y, input bit de);
    int  p;
    bit  busy;
    p    = (x + refOff) % STRIP_PX;
    busy = inRows(y) && (x <= 639);
    sx = 10'(x);
    sy = 10'(y);
    data_en = de;
    @(posedge clk_pix); #1;
    if (busy) checkOutput("fetch_addr", 32'(ram_addr), p / 8);
    if (pendValid) begin
      checkOutput("char_code", 32'(char_code), pendCode);
      checkOutput("font_row", 32'(font_row), pendRow);
      checkOutput("font_col", 32'(font_col), pendCol);
      checkOutput("strip_en", 32'(strip_en), pendEn);
    end
    pendValid = 1;
    pendCode  = busy ? int'(refMem[p / 8]) : 0;
    pendRow   = (y - ROW_TOP + 1024) % 16;
    pendCol   = p % 8;
    pendEn    = (inRows(y) && de) ? 1 : 0;
  endtask

  task automatic flushPipe();
    applyStimulus(700, 100, 1'b0);
    pendValid = 0;
  endtask

  task automatic doFrame(input bit en);
    enable = en;
    applyStimulus(0, 480, 1'b0);
    if (en) refOff = (refOff + SPEED) % STRIP_PX;
  endtask

  task automatic hostWrite(input int addr, input int data, input bit holdExtra);
    int waitc;
    pendValid = 0;
    sx = 10'd700;
    sy = 10'd100;
    data_en = 1'b0;
    wr_addr = ADDR_W'(addr);
    wr_data = 8'(data);
    wr_req  = 1'b1;
    @(posedge clk_pix); #1;
    waitc = 1;
    while (!wr_gnt && waitc < 8) begin
      @(posedge clk_pix); #1;
      waitc++;
    end
    checkOutput("gnt_latency", waitc, 1);
    if (wr_gnt) begin
      checkOutput("gnt_we", 32'(ram_we), 1);
      checkOutput("gnt_addr", 32'(ram_addr), addr);
      checkOutput("gnt_wdata", 32'(ram_wdata), data);
      refMem[addr] = 8'(data);
    end
    if (holdExtra) begin
      @(posedge clk_pix); #1;
      checkOutput("held_no_regrant", 32'(wr_gnt), 0);
    end
    wr_req = 1'b0;
    @(posedge clk_pix); #1;
    checkOutput("gnt_drop", 32'(wr_gnt), 0);
    checkOutput("we_drop", 32'(ram_we), 0);
    @(posedge clk_pix); #1;
  endtask

  initial begin
    int gntSx, nGnt, waitc, guard, d;
    rst = 1'b1; sx = '0; sy = '0; data_en = 1'b0; enable = 1'b1;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) @(posedge clk_pix);
    #1;
    rst = 1'b0;

    $display("[TB] preload character ring through the host port");
    for (int i = 0; i < TEXT_LEN; i++) hostWrite(i, $urandom_range(1, 255), 1'b0);

    $display("[TB] blanking write with request held an extra cycle");
    hostWrite(5, 8'h41, 1'b1);

    $display("[TB] mid-frame reset");
    for (int i = 0; i < 3; i++) doFrame(1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(300 + i, ROW_TOP + 6, 1'b1);
    pendValid = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk_pix);
    #1;
    checkOutput("rst_char_code", 32'(char_code), 0);
    checkOutput("rst_font_row", 32'(font_row), 0);
    checkOutput("rst_font_col", 32'(font_col), 0);
    checkOutput("rst_strip_en", 32'(strip_en), 0);
    checkOutput("rst_ram_addr", 32'(ram_addr), 0);
    checkOutput("rst_ram_we", 32'(ram_we), 0);
    checkOutput("rst_ram_wdata", 32'(ram_wdata), 0);
    checkOutput("rst_wr_gnt", 32'(wr_gnt), 0);
    rst = 1'b0;
    refOff = 0;
    applyStimulus(0, ROW_TOP, 1'b1);
    flushPipe();

    $display("[TB] scroll steps");
    doFrame(1'b1);
    applyStimulus(0, ROW_TOP, 1'b1);
    for (int i = 0; i < 3; i++) doFrame(1'b1);
    applyStimulus(0, ROW_TOP, 1'b1);
    flushPipe();

    $display("[TB] random pixels and frames");
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) doFrame(1'($urandom_range(0, 1)));
      else applyStimulus($urandom_range(0, 799), $urandom_range(ROW_TOP - 4, ROW_TOP + CHAR_H + 3),
                         1'($urandom_range(0, 1)));
    end
    flushPipe();

    $display("[TB] offset wrap");
    guard = 0;
    while (refOff != STRIP_PX - SPEED && guard < 300) begin
      doFrame(1'b1);
      guard++;
    end
    applyStimulus(0, ROW_TOP + 1, 1'b1);
    doFrame(1'b1);
    applyStimulus(0, ROW_TOP, 1'b1);
    applyStimulus(1, ROW_TOP, 1'b1);
    flushPipe();

    $display("[TB] write contending with display fetch");
    d = $urandom_range(0, 255);
    wr_addr = 6'd7;
    wr_data = 8'(d);
    wr_req  = 1'b1;
    gntSx = -1;
    nGnt  = 0;
    for (int x = 100; x <= 650; x++) begin
      applyStimulus(x, ROW_TOP + 3, 1'($urandom_range(0, 1)));
      if (wr_gnt) begin
        nGnt++;
        if (gntSx < 0) begin
          gntSx = x;
          checkOutput("cont_we", 32'(ram_we), 1);
          checkOutput("cont_addr", 32'(ram_addr), 7);
          checkOutput("cont_wdata", 32'(ram_wdata), d);
          refMem[7] = 8'(d);
        end
        wr_req = 1'b0;
      end
    end
    flushPipe();
    checkOutput("cont_gnt_count", nGnt, 1);
    checkOutput("cont_gnt_window", 32'((gntSx >= 640) && (gntSx <= 642)), 1);
    for (int x = 50; x < 60; x++) applyStimulus(x, ROW_TOP + 9, 1'b1);
    flushPipe();

    $display("[TB] frozen scroll");
    for (int i = 0; i < 3; i++) begin
      doFrame(1'b0);
      applyStimulus($urandom_range(0, 639), ROW_TOP + i, 1'b1);
    end
    applyStimulus(0, ROW_TOP, 1'b1);
    enable = 1'b1;
    flushPipe();

    $display("[TB] reset during a write");
    d = $urandom_range(0, 255);
    sx = 10'd700; sy = 10'd100;
    wr_addr = 6'd9;
    wr_data = 8'(d);
    wr_req  = 1'b1;
    @(posedge clk_pix); #1;
    checkOutput("rw_first_gnt", 32'(wr_gnt), 1);
    refMem[9] = 8'(d);
    rst = 1'b1;
    @(posedge clk_pix); #1;
    checkOutput("rw_rst_we", 32'(ram_we), 0);
    checkOutput("rw_rst_gnt", 32'(wr_gnt), 0);
    rst = 1'b0;
    refOff = 0;
    @(posedge clk_pix); #1;
    waitc = 1;
    while (!wr_gnt && waitc < 8) begin
      @(posedge clk_pix); #1;
      waitc++;
    end
    checkOutput("rw_regrant_latency", waitc, 1);
    checkOutput("rw_regrant_addr", 32'(ram_addr), 9);
    checkOutput("rw_regrant_we", 32'(ram_we), 1);
    wr_req = 1'b0;
    repeat (2) @(posedge clk_pix);
    #1;
    applyStimulus(8, ROW_TOP + 15, 1'b1);
    applyStimulus(72, ROW_TOP + 2, 1'b1);
    flushPipe();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
